// File: rtl/divmmc_pkg.sv
// Shared definitions for the DivMMC SD/MMC SPI arbiter: owner codes, arbiter states and
// the idle byte sent when a requester only wants to receive.
package divmmc_pkg;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StOwnA,
    StOwnB,
    StGap
  } arb_state_e;

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI byte shifter: 16 phases per byte, MSB first, one-cycle done pulse after the byte.
module spi_byte_engine
  import divmmc_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       tx,
  input  logic       rx,
  input  logic [7:0] din,
  input  logic       spi_di,
  output logic       busy,
  output logic       done,
  output logic       capture,
  output logic [7:0] rx_byte,
  output logic       spi_clk,
  output logic       spi_do
);

  logic       busy_q;
  logic       done_q;
  logic [3:0] phase_q;
  logic [7:0] shift_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= 4'd0;
      shift_q <= SPI_IDLE_BYTE;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        phase_q <= phase_q + 4'd1;
        if (phase_q[0]) begin
          shift_q <= {shift_q[6:0], spi_di};
        end
        if (phase_q == 4'd15) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (tx || rx) begin
        busy_q  <= 1'b1;
        phase_q <= 4'd0;
        shift_q <= tx ? din : SPI_IDLE_BYTE;
      end
    end
  end

  // Final received byte is valid during phase 15, including the bit sampled at its end.
  assign capture = busy_q && (phase_q == 4'd15);
  assign rx_byte = {shift_q[6:0], spi_di};
  assign busy    = busy_q;
  assign done    = done_q;
  assign spi_clk = busy_q & phase_q[0];
  assign spi_do  = busy_q ? shift_q[7] : 1'b1;

endmodule

// File: rtl/divmmc_spi_arbiter.sv
// Shares the SD SPI bus between the DivMMC port logic (A) and a block loader (B), one
// chip-select transaction at a time, with a forced deselect gap between owners.
module divmmc_spi_arbiter
  import divmmc_pkg::*;
#(
  parameter bit          PRIO_B     = 1'b0,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       a_ss,
  input  logic       a_tx,
  input  logic       a_rx,
  input  logic [7:0] a_din,
  output logic [7:0] a_dout,
  output logic       a_done,
  output logic       a_drop,
  input  logic       b_ss,
  input  logic       b_tx,
  input  logic       b_rx,
  input  logic [7:0] b_din,
  output logic [7:0] b_dout,
  output logic       b_done,
  output logic       b_drop,
  output logic [1:0] owner,
  output logic       spi_ss,
  output logic       spi_clk,
  output logic       spi_do,
  input  logic       spi_di
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  arb_state_e      state_q;
  logic [GapW-1:0] gap_q;
  logic [7:0]      a_dout_q, b_dout_q;
  logic            a_drop_q, b_drop_q;

  logic       eng_busy, eng_done, eng_capture;
  logic [7:0] eng_rx_byte;

  // A strobe is only taken while its port owns the bus, still holds ss low and the engine is free.
  logic accept_a, accept_b, strobe_a, strobe_b, go_a, go_b;
  assign strobe_a = a_tx | a_rx;
  assign strobe_b = b_tx | b_rx;
  assign accept_a = (state_q == StOwnA) && !a_ss && !eng_busy;
  assign accept_b = (state_q == StOwnB) && !b_ss && !eng_busy;
  assign go_a     = accept_a & strobe_a;
  assign go_b     = accept_b & strobe_b;

  logic       eng_tx, eng_rx;
  logic [7:0] eng_din;
  assign eng_tx  = (go_a & a_tx) | (go_b & b_tx);
  assign eng_rx  = (go_a & a_rx & ~a_tx) | (go_b & b_rx & ~b_tx);
  assign eng_din = go_b ? b_din : a_din;

  spi_byte_engine u_engine (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tx      (eng_tx),
    .rx      (eng_rx),
    .din     (eng_din),
    .spi_di  (spi_di),
    .busy    (eng_busy),
    .done    (eng_done),
    .capture (eng_capture),
    .rx_byte (eng_rx_byte),
    .spi_clk (spi_clk),
    .spi_do  (spi_do)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      a_dout_q <= SPI_IDLE_BYTE;
      b_dout_q <= SPI_IDLE_BYTE;
      a_drop_q <= 1'b0;
      b_drop_q <= 1'b0;
    end else begin
      a_drop_q <= strobe_a & ~accept_a;
      b_drop_q <= strobe_b & ~accept_b;

      if (eng_capture) begin
        if (state_q == StOwnA) a_dout_q <= eng_rx_byte;
        if (state_q == StOwnB) b_dout_q <= eng_rx_byte;
      end

      unique case (state_q)
        StIdle: begin
          gap_q <= '0;
          if (!a_ss && (b_ss || !PRIO_B)) begin
            state_q <= StOwnA;
          end else if (!b_ss) begin
            state_q <= StOwnB;
          end
        end
        StOwnA: if (a_ss && !eng_busy) state_q <= StGap;
        StOwnB: if (b_ss && !eng_busy) state_q <= StGap;
        StGap: begin
          if (gap_q == GapLast) begin
            gap_q   <= '0;
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end
      endcase
    end
  end

  // A release mid-byte keeps the card selected until the byte finishes.
  always_comb begin
    spi_ss = 1'b1;
    owner  = OWN_NONE;
    unique case (state_q)
      StOwnA: begin
        spi_ss = a_ss & ~eng_busy;
        owner  = OWN_A;
      end
      StOwnB: begin
        spi_ss = b_ss & ~eng_busy;
        owner  = OWN_B;
      end
      default: begin
        spi_ss = 1'b1;
        owner  = OWN_NONE;
      end
    endcase
  end

  assign a_dout = a_dout_q;
  assign b_dout = b_dout_q;
  assign a_drop = a_drop_q;
  assign b_drop = b_drop_q;
  assign a_done = eng_done && (state_q == StOwnA);
  assign b_done = eng_done && (state_q == StOwnB);

endmodule

// File: tb/tb_divmmc_spi_arbiter.sv
// Directed bench for divmmc_spi_arbiter: arbitration, gap, strobe dropping, byte timing and reset abort.
module tb_divmmc_spi_arbiter;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       a_ss = 1'b1, a_tx = 1'b0, a_rx = 1'b0;
  logic [7:0] a_din = 8'h00;
  logic       b_ss = 1'b1, b_tx = 1'b0, b_rx = 1'b0;
  logic [7:0] b_din = 8'h00;
  logic [7:0] a_dout, b_dout;
  logic       a_done, a_drop, b_done, b_drop;
  logic [1:0] owner;
  logic       spi_ss, spi_clk, spi_do, spi_di;

  logic loop   = 1'b1;
  logic di_val = 1'b0;
  assign spi_di = loop ? spi_do : di_val;

  divmmc_spi_arbiter #(
    .PRIO_B     (1'b0),
    .GAP_CYCLES (4)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .a_ss    (a_ss),
    .a_tx    (a_tx),
    .a_rx    (a_rx),
    .a_din   (a_din),
    .a_dout  (a_dout),
    .a_done  (a_done),
    .a_drop  (a_drop),
    .b_ss    (b_ss),
    .b_tx    (b_tx),
    .b_rx    (b_rx),
    .b_din   (b_din),
    .b_dout  (b_dout),
    .b_done  (b_done),
    .b_drop  (b_drop),
    .owner   (owner),
    .spi_ss  (spi_ss),
    .spi_clk (spi_clk),
    .spi_do  (spi_do),
    .spi_di  (spi_di)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int a_done_cnt = 0;
  logic [7:0] mosi = 8'h00;

  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(posedge clk_sys) if (a_done === 1'b1) a_done_cnt <= a_done_cnt + 1;
  always @(posedge spi_clk) begin
    rise_cnt <= rise_cnt + 1;
    mosi     <= {mosi[6:0], spi_do};
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit port_b, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if ((port_b ? b_done : a_done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $error("FAIL done_timeout observed=none expected=done_within_40");
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int s, at, r0, d0;

  initial begin
    // 1: reset and idle
    idle_steps(3);
    reset = 1'b0;
    step();
    check("rst_spi_ss", spi_ss, 1);
    check("rst_owner", owner, 0);
    check("rst_a_dout", a_dout, 8'hFF);
    check("rst_b_dout", b_dout, 8'hFF);
    check("rst_spi_do", spi_do, 1);
    idle_steps(100);
    check("idle_clk_static", rise_cnt, 0);

    // 2: port A transmits A5 with loopback
    a_ss = 1'b0;
    step();
    check("a_grant_owner", owner, 1);
    check("a_grant_ss", spi_ss, 0);
    r0 = rise_cnt;
    a_din = 8'hA5; a_tx = 1'b1; s = cyc;
    step();
    a_tx = 1'b0;
    wait_done(1'b0, at);
    check("tx_latency", at - s, 17);
    check("tx_rises", rise_cnt - r0, 8);
    check("tx_mosi", mosi, 8'hA5);
    check("tx_a_dout", a_dout, 8'hA5);
    check("tx_b_dout_hold", b_dout, 8'hFF);
    step();
    check("tx_done_pulse", a_done, 0);
    a_ss = 1'b1;
    idle_steps(8);

    // 3: simultaneous request, A wins; B strobe dropped; gap then B granted
    a_ss = 1'b0; b_ss = 1'b0;
    step();
    check("tie_owner", owner, 1);
    r0 = rise_cnt;
    b_din = 8'h33; b_tx = 1'b1;
    step();
    b_tx = 1'b0;
    check("tie_b_drop", b_drop, 1);
    a_ss = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("gap_ss", spi_ss, 1);
      check("gap_owner", owner, 0);
      step();
    end
    check("gap_idle_owner", owner, 0);
    step();
    check("b_grant_owner", owner, 2);
    check("b_grant_ss", spi_ss, 0);
    check("b_drop_no_bus", rise_cnt - r0, 0);
    b_din = 8'h3C; b_tx = 1'b1; s = cyc;
    step();
    b_tx = 1'b0;
    wait_done(1'b1, at);
    check("b_latency", at - s, 17);
    check("b_dout", b_dout, 8'h3C);
    check("b_a_dout_hold", a_dout, 8'hA5);
    b_ss = 1'b1;
    idle_steps(8);

    // 4: rx while busy dropped; rx on done cycle accepted back to back
    loop = 1'b0; di_val = 1'b0;
    a_ss = 1'b0;
    step();
    r0 = rise_cnt;
    a_rx = 1'b1; s = cyc;
    step();
    a_rx = 1'b0;
    idle_steps(2);
    a_rx = 1'b1;
    step();
    a_rx = 1'b0;
    check("busy_a_drop", a_drop, 1);
    wait_done(1'b0, at);
    check("rx_latency", at - s, 17);
    check("rx_rises", rise_cnt - r0, 8);
    check("rx_a_dout", a_dout, 8'h00);
    di_val = 1'b1;
    a_rx = 1'b1; s = cyc;
    step();
    a_rx = 1'b0;
    check("b2b_no_drop", a_drop, 0);
    wait_done(1'b0, at);
    check("b2b_latency", at - s, 17);
    check("b2b_a_dout", a_dout, 8'hFF);
    check("b2b_rises", rise_cnt - r0, 16);
    a_ss = 1'b1; loop = 1'b1;
    idle_steps(8);

    // 5: release at phase 6 holds ss low until the byte ends
    a_ss = 1'b0;
    step();
    a_din = 8'h5A; a_tx = 1'b1; s = cyc;
    step();
    a_tx = 1'b0;
    idle_steps(6);
    a_ss = 1'b1;
    #1;
    check("rel_ss_low", spi_ss, 0);
    idle_steps(9);
    check("rel_ss_low_p15", spi_ss, 0);
    step();
    check("rel_done", a_done, 1);
    check("rel_a_dout", a_dout, 8'h5A);
    step();
    check("rel_gap_owner", owner, 0);
    check("rel_gap_ss", spi_ss, 1);
    idle_steps(8);

    // 6: reset at phase 9 aborts the byte
    a_ss = 1'b0;
    step();
    a_din = 8'h81; a_tx = 1'b1;
    step();
    a_tx = 1'b0;
    idle_steps(9);
    reset = 1'b1; a_ss = 1'b1;
    d0 = a_done_cnt;
    step();
    check("abort_ss", spi_ss, 1);
    check("abort_clk", spi_clk, 0);
    check("abort_owner", owner, 0);
    check("abort_a_dout", a_dout, 8'hFF);
    reset = 1'b0;
    idle_steps(20);
    check("abort_no_done", a_done_cnt - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
